modaddsub_stage: RTL and testbench

MODADDSUB_STAGE -- requirements
Module: modaddsub_stage

---
 rtl/modaddsub_stage_pkg.sv | 11 +
 rtl/modaddsub_stage_if.sv | 34 +++
 rtl/modaddsub_stage_modcorrect.sv | 29 ++
 rtl/modaddsub_stage.sv | 151 +++++++++++++++
 tb/tb_modaddsub_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/modaddsub_stage_pkg.sv
// Shared defaults for the modular add/sub butterfly stage.
package modaddsub_stage_pkg;

   // Coefficient / modulus width in bits.
   localparam int DEFAULT_LOGQ      = 32;
   // Pipeline depth in cycles (legal 1..8).
   localparam int DEFAULT_DELAY_ADD = 2;
   // Width of the completed-transfer counter.
   localparam int DEFAULT_CNTW      = 16;

endpackage

// File: rtl/modaddsub_stage_if.sv
// Operand/result handshake bundle for modaddsub_stage.
// The slave side is the stage itself; the master side is whoever feeds it
// operands and drains its results.
interface modaddsub_stage_if
   import modaddsub_stage_pkg::*;
#(
   parameter int LOGQ = DEFAULT_LOGQ,
   parameter int CNTW = DEFAULT_CNTW
);

   logic            intt;
   logic            in_valid;
   logic            in_ready;
   logic [LOGQ-1:0] a;
   logic [LOGQ-1:0] b;
   logic [LOGQ-1:0] q;
   logic            out_valid;
   logic            out_ready;
   logic [LOGQ-1:0] sum;
   logic [LOGQ-1:0] dif;
   logic            out_intt;
   logic [CNTW-1:0] xfer_cnt;

   modport slave (
      input  intt, in_valid, a, b, q, out_ready,
      output in_ready, out_valid, sum, dif, out_intt, xfer_cnt
   );

   modport master (
      output intt, in_valid, a, b, q, out_ready,
      input  in_ready, out_valid, sum, dif, out_intt, xfer_cnt
   );

endinterface

// File: rtl/modaddsub_stage_modcorrect.sv
// Final-stage modular correction of a raw LOGQ+1-bit add or subtract result.
// SUB=1: sum path, subtract q when raw >= q.
// SUB=0: difference path, add q back when raw carries a borrow (MSB set).
// The corrected value always fits in LOGQ bits, so the adjust arithmetic is
// done modulo 2^LOGQ on the low bits only.
module modcorrect
   import modaddsub_stage_pkg::*;
#(
   parameter int LOGQ = DEFAULT_LOGQ,
   parameter bit SUB  = 1'b1
)(
   input  logic [LOGQ:0]   raw,
   input  logic [LOGQ-1:0] q,
   output logic [LOGQ-1:0] res
);

   if (SUB) begin : g_sub
      logic [LOGQ-1:0] adj;
      assign adj = raw[LOGQ-1:0] - q;
      // Full-width compare so a carry out of a+b is honoured.
      assign res = (raw >= {1'b0, q}) ? adj : raw[LOGQ-1:0];
   end else begin : g_add
      logic [LOGQ-1:0] adj;
      assign adj = raw[LOGQ-1:0] + q;
      // MSB of a-b in LOGQ+1 bits is the borrow (negative result).
      assign res = raw[LOGQ] ? adj : raw[LOGQ-1:0];
   end

endmodule

// File: rtl/modaddsub_stage.sv
// Pipelined modular add/subtract stage: sum=(a+b) mod q, dif=(a-b) mod q.
// Stage 1 registers the raw LOGQ+1-bit add/sub, middle stages only delay,
// and the final stage registers the corrected results. With DELAY_ADD=1 the
// raw and correction steps share the single stage. Every register, valid
// and tag bits included, loads only on advance, so a stalled consumer
// freezes the whole pipe instead of dropping items.
module modaddsub_stage
   import modaddsub_stage_pkg::*;
#(
   parameter int LOGQ      = DEFAULT_LOGQ,
   parameter int DELAY_ADD = DEFAULT_DELAY_ADD,
   parameter int CNTW      = DEFAULT_CNTW
)(
   input logic               clk,
   input logic               rst_n,
   modaddsub_stage_if.slave  bus
);

   // Raw-value stages sit in front of the final stage; keep at least one
   // array slot so the declaration stays legal for DELAY_ADD=1.
   localparam int RAWN = (DELAY_ADD > 1) ? DELAY_ADD - 1 : 1;

   logic            vld [DELAY_ADD];
   logic            tag [DELAY_ADD];
   logic [LOGQ:0]   s_raw [RAWN];
   logic [LOGQ:0]   d_raw [RAWN];

   logic            advance;
   logic [LOGQ:0]   s_in;
   logic [LOGQ:0]   d_in;
   logic [LOGQ:0]   s_fin;
   logic [LOGQ:0]   d_fin;
   logic [LOGQ-1:0] sum_c;
   logic [LOGQ-1:0] dif_c;
   logic [LOGQ-1:0] sum_reg;
   logic [LOGQ-1:0] dif_reg;
   logic [CNTW-1:0] cnt_reg;

   // Pipe moves whenever the output slot is empty or being drained.
   assign advance = ~(vld[DELAY_ADD-1] & ~bus.out_ready);

   // Raw add/sub in LOGQ+1 bits; the MSB of d_in is the borrow.
   assign s_in = {1'b0, bus.a} + {1'b0, bus.b};
   assign d_in = {1'b0, bus.a} - {1'b0, bus.b};

   genvar gi;

   // Valid/tag shift chain, one enabled flop per stage.
   for (gi = 0; gi < DELAY_ADD; gi++) begin : g_ctl
      if (gi == 0) begin : g_head
         // First stage captures the incoming valid and mode tag.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld[gi] <= 1'b0;
               tag[gi] <= 1'b0;
            end else if (advance) begin
               vld[gi] <= bus.in_valid;
               tag[gi] <= bus.intt;
            end
         end
      end else begin : g_body
         // Later stages take the previous stage's valid and tag.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld[gi] <= 1'b0;
               tag[gi] <= 1'b0;
            end else if (advance) begin
               vld[gi] <= vld[gi-1];
               tag[gi] <= tag[gi-1];
            end
         end
      end
   end

   // Raw-result stages in front of the final correction stage.
   for (gi = 0; gi < DELAY_ADD - 1; gi++) begin : g_raw
      if (gi == 0) begin : g_head
         // Stage 1 registers the uncorrected add/sub.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_raw[gi] <= '0;
               d_raw[gi] <= '0;
            end else if (advance) begin
               s_raw[gi] <= s_in;
               d_raw[gi] <= d_in;
            end
         end
      end else begin : g_body
         // Pure delay stages between stage 1 and the final stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_raw[gi] <= '0;
               d_raw[gi] <= '0;
            end else if (advance) begin
               s_raw[gi] <= s_raw[gi-1];
               d_raw[gi] <= d_raw[gi-1];
            end
         end
      end
   end

   // Source of the correction step: live inputs for a single-stage pipe,
   // otherwise the last raw stage.
   if (DELAY_ADD == 1) begin : g_fin_direct
      assign s_fin = s_in;
      assign d_fin = d_in;
   end else begin : g_fin_piped
      assign s_fin = s_raw[DELAY_ADD-2];
      assign d_fin = d_raw[DELAY_ADD-2];
   end

   modcorrect #(.LOGQ(LOGQ), .SUB(1'b1)) u_sum_corr (
      .raw (s_fin),
      .q   (bus.q),
      .res (sum_c)
   );

   modcorrect #(.LOGQ(LOGQ), .SUB(1'b0)) u_dif_corr (
      .raw (d_fin),
      .q   (bus.q),
      .res (dif_c)
   );

   // Final stage holds the corrected results; frozen while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg <= '0;
         dif_reg <= '0;
      end else if (advance) begin
         sum_reg <= sum_c;
         dif_reg <= dif_c;
      end
   end

   // Count completed output transfers, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (vld[DELAY_ADD-1] && bus.out_ready) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = vld[DELAY_ADD-1];
   assign bus.out_intt  = tag[DELAY_ADD-1];
   assign bus.sum       = sum_reg;
   assign bus.dif       = dif_reg;
   assign bus.xfer_cnt  = cnt_reg;

endmodule

// File: tb/tb_modaddsub_stage.sv
// Scoreboard bench for modaddsub_stage (LOGQ=8, q=97, DELAY_ADD=2).
// A second instance with CNTW=4 shares the stimulus to exercise counter wrap.
module tb_modaddsub_stage;

   localparam int LOGQ      = 8;
   localparam int DELAY_ADD = 2;
   localparam int CNTW      = 16;
   localparam int QMOD      = 97;

   typedef struct {
      logic [7:0] s;
      logic [7:0] d;
      logic       t;
      int         acc;
      bit         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_mode = 1'b0;
   bit   front_seen = 1'b0;
   exp_t sb[$];

   modaddsub_stage_if #(.LOGQ(LOGQ), .CNTW(CNTW)) bus ();
   modaddsub_stage_if #(.LOGQ(LOGQ), .CNTW(4))    bus4 ();

   modaddsub_stage #(.LOGQ(LOGQ), .DELAY_ADD(DELAY_ADD), .CNTW(CNTW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   modaddsub_stage #(.LOGQ(LOGQ), .DELAY_ADD(DELAY_ADD), .CNTW(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   assign bus4.intt      = bus.intt;
   assign bus4.in_valid  = bus.in_valid;
   assign bus4.a         = bus.a;
   assign bus4.b         = bus.b;
   assign bus4.q         = bus.q;
   assign bus4.out_ready = bus.out_ready;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_sum(input int av, input int bv);
      return 8'((av + bv) % QMOD);
   endfunction

   function automatic logic [7:0] ref_dif(input int av, input int bv);
      return 8'((av - bv + QMOD) % QMOD);
   endfunction

   // Output side compares against the queue head; input side pushes the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 32'd1, 32'd0);
            end else begin
               if (!front_seen) begin
                  front_seen = 1'b1;
                  if (sb[0].lat) check("latency", 32'(cyc - sb[0].acc), 32'(DELAY_ADD));
               end
               check("sum", 32'(bus.sum), 32'(sb[0].s));
               check("dif", 32'(bus.dif), 32'(sb[0].d));
               check("out_intt", 32'(bus.out_intt), 32'(sb[0].t));
               if (bus.out_ready) begin
                  $display("xfer: sum=%0d dif=%0d intt=%0d cnt=%0d",
                           bus.sum, bus.dif, bus.out_intt, bus.xfer_cnt);
                  void'(sb.pop_front());
                  front_seen = 1'b0;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.s   = ref_sum(int'(bus.a), int'(bus.b));
            e.d   = ref_dif(int'(bus.a), int'(bus.b));
            e.t   = bus.intt;
            e.acc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
         end
      end
   end

   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic tv);
      int  n = 0;
      bit  acc = 1'b0;
      bus.a = av;
      bus.b = bv;
      bus.intt = tv;
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      sb.delete();
      front_seen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.intt = 1'b0;
      bus.q = 8'(QMOD);
      bus.out_ready = 1'b1;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
      check("rst_sum", 32'(bus.sum), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed values, including the modulus boundaries.
      lat_mode = 1'b1;
      send(8'd50, 8'd60, 1'b1);
      send(8'd96, 8'd96, 1'b0);
      send(8'd0, 8'd96, 1'b1);
      drain();
      check("directed_xfer_cnt", 32'(bus.xfer_cnt), 32'd3);

      // Reset with two items in flight: nothing may survive it.
      lat_mode = 1'b0;
      send(8'd10, 8'd20, 1'b0);
      send(8'd30, 8'd40, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
      check("midrst_out_intt", 32'(bus.out_intt), 32'd0);
      sb.delete();
      front_seen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(6);
      check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("postrst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);

      // Alternating tags with random gaps; 17 transfers wraps the 4-bit counter.
      lat_mode = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(8'($urandom_range(0, QMOD-1)), 8'($urandom_range(0, QMOD-1)), (i % 2) == 0);
         idle($urandom_range(0, 2));
      end
      drain();
      check("tag_xfer_cnt", 32'(bus.xfer_cnt), 32'd17);
      check("cnt4_wrap", 32'(bus4.xfer_cnt), 32'd1);

      // Back-to-back stream with a 5-cycle consumer stall mid-stream.
      do_reset();
      lat_mode = 1'b0;
      fork
         begin
            for (int i = 0; i < 64; i++)
               send(8'($urandom_range(0, QMOD-1)), 8'($urandom_range(0, QMOD-1)),
                    1'($urandom_range(0, 1)));
         end
         begin
            repeat (20) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("stream_xfer_cnt", 32'(bus.xfer_cnt), 32'd64);
      check("stream_out_valid", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
